// File: rtl/vec_pkg.sv
// Shared definitions for the vector datapath components.
//   VEC_N  - default element width in bits
//   VEC_M  - default lane count
//   VEC_AW - default memory address width
//   vseq_state_t - state encoding of the vector memory sequencer
package vec_pkg;

    localparam int unsigned VEC_N  = 16;
    localparam int unsigned VEC_M  = 16;
    localparam int unsigned VEC_AW = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } vseq_state_t;

endpackage

// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: splits one M-lane x N-bit vector memory operation into M
// single-element accesses on a scalar memory port.
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   start_i, we_i   - operation request and type (1 = store), accepted only when idle
//   base_addr_i     - lane-0 address
//   stride_i        - address increment between lanes (modulo 2^AW)
//   wdata_i         - store vector
//   busy_o, done_o  - operation in flight / one-cycle completion pulse
//   rdata_o         - last completed load vector
//   mem_*           - scalar memory port; an access completes on mem_ack_i while mem_req_o
module vec_mem_sequencer
    import vec_pkg::*;
#(
    parameter int unsigned N  = VEC_N,
    parameter int unsigned M  = VEC_M,
    parameter int unsigned AW = VEC_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                we_i,
    input  logic [AW-1:0]       base_addr_i,
    input  logic [AW-1:0]       stride_i,
    input  logic [M-1:0][N-1:0] wdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [M-1:0][N-1:0] rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [N-1:0]        mem_wdata_o,
    input  logic [N-1:0]        mem_rdata_i,
    input  logic                mem_ack_i
);

    localparam int unsigned IW = $clog2(M);
    localparam logic [IW-1:0] LastIdx = IW'(M - 1);

    vseq_state_t         state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW-1:0]       stride_q, stride_d;
    logic [M-1:0][N-1:0] wbuf_q, wbuf_d;
    logic [M-1:0][N-1:0] shadow_q, shadow_d;
    logic [M-1:0][N-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        wbuf_d   = wbuf_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StReq;
                    we_d     = we_i;
                    addr_d   = base_addr_i;
                    stride_d = stride_i;
                    wbuf_d   = wdata_i;
                    idx_d    = '0;
                end
            end
            StReq: begin
                if (mem_ack_i) begin
                    if (!we_q) begin
                        shadow_d[idx_q] = mem_rdata_i;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                        // Publish the whole vector at once, final lane included, so
                        // rdata never exposes a partially assembled load.
                        if (!we_q) begin
                            rdata_d = shadow_d;
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        addr_d = addr_q + stride_q;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            stride_q <= '0;
            wbuf_q   <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            wbuf_q   <= wbuf_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign mem_req_o   = (state_q == StReq);
    assign mem_we_o    = (state_q == StReq) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wbuf_q[idx_q];
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: directed table of operations plus randomized
// operations, each checked cycle by cycle against a lane-level reference model.
module tb_vec_mem_sequencer;

    localparam int N  = 16;
    localparam int M  = 16;
    localparam int AW = 16;
    localparam int W  = M * N;

    logic                clk;
    logic                rst_n;
    logic                start_i;
    logic                we_i;
    logic [AW-1:0]       base_addr_i;
    logic [AW-1:0]       stride_i;
    logic [M-1:0][N-1:0] wdata_i;
    logic                busy_o;
    logic                done_o;
    logic [M-1:0][N-1:0] rdata_o;
    logic                mem_req_o;
    logic                mem_we_o;
    logic [AW-1:0]       mem_addr_o;
    logic [N-1:0]        mem_wdata_o;
    logic [N-1:0]        mem_rdata_i;
    logic                mem_ack_i;

    vec_mem_sequencer #(.N(N), .M(M), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .we_i        (we_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .wdata_i     (wdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [M-1:0][N-1:0] exp_rdata;

    typedef struct {
        logic          we;
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        int            ack_period;  // 0 = random acks
        bit            rnd;         // random store / load data
        int            start_cyc;   // cycle of an extra start while busy (0 = none)
        int            rst_after;   // reset after this many acks (0 = none)
        int            exp_done;    // required done cycle (0 = not fixed)
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_req"}, mem_req_o, 1'b0);
        chk({tag, "_we"}, mem_we_o, 1'b0);
        chk({tag, "_addr"}, mem_addr_o, '0);
        chk({tag, "_wdata"}, mem_wdata_o, '0);
        chk({tag, "_rdata"}, rdata_o, '0);
    endtask

    // Runs one operation; cycle 1 is the first cycle after the edge that samples start.
    task automatic run_op(input vec_t v);
        logic [M-1:0][N-1:0] wd;
        logic [M-1:0][N-1:0] coll;
        logic [AW-1:0]       ea;
        logic                ack;
        int                  cyc;
        int                  lane;
        int                  w;
        int                  acks;
        int                  last_ack;
        bit                  in_done;

        for (int i = 0; i < M; i++) begin
            wd[i] = v.rnd ? N'($urandom) : N'(16'hA000 + i);
        end
        coll = '0;

        @(posedge clk); #1;
        start_i     = 1'b1;
        we_i        = v.we;
        base_addr_i = v.base;
        stride_i    = v.stride;
        wdata_i     = wd;
        mem_ack_i   = 1'b0;
        @(posedge clk); #1;
        // Scramble sampled inputs: the operation must run from its captured copies.
        start_i     = 1'b0;
        we_i        = 1'($urandom);
        base_addr_i = AW'($urandom);
        stride_i    = AW'($urandom);
        for (int i = 0; i < M; i++) wdata_i[i] = N'($urandom);

        cyc = 1; lane = 0; w = 0; acks = 0; last_ack = -1;
        forever begin
            in_done = (last_ack >= 0);
            chk("busy", busy_o, 1'b1);
            chk("done", done_o, in_done);
            chk("mem_req", mem_req_o, !in_done);
            if (!in_done) begin
                ea = v.base + AW'(lane) * v.stride;
                chk("mem_addr", mem_addr_o, ea);
                chk("mem_we", mem_we_o, v.we);
                if (v.we) chk("mem_wdata", mem_wdata_o, wd[lane]);
                chk("rdata_hold", rdata_o, exp_rdata);
            end else begin
                if (v.exp_done > 0) chk("done_cycle", cyc, v.exp_done);
                if (!v.we) exp_rdata = coll;
                chk("rdata_done", rdata_o, exp_rdata);
                break;
            end

            ack         = (v.ack_period > 0) ? (w == v.ack_period - 1) : 1'($urandom_range(0, 1));
            mem_ack_i   = ack;
            mem_rdata_i = v.rnd ? N'($urandom) : N'(mem_addr_o);
            if (cyc == v.start_cyc) begin
                start_i     = 1'b1;
                we_i        = 1'b0;
                base_addr_i = v.base ^ 16'h5555;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            if (ack) begin
                coll[lane] = mem_rdata_i;
                lane++;
                acks++;
                w = 0;
                if (lane == M) last_ack = cyc;
            end else begin
                w++;
            end
            cyc++;

            if (v.rst_after > 0 && acks == v.rst_after) begin
                mem_ack_i = 1'b0;
                rst_n     = 1'b0;
                #1;
                exp_rdata = '0;
                chk_all_zero("midrst");
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    mem_ack_i = 1'($urandom);
                    @(posedge clk); #1;
                    chk("midrst_idle_busy", busy_o, 1'b0);
                    chk("midrst_no_done", done_o, 1'b0);
                end
                mem_ack_i = 1'b0;
                return;
            end
            if (cyc > 400) begin
                chk("timeout", 1'b0, 1'b1);
                return;
            end
        end

        // An ack with no request outstanding must be ignored.
        mem_ack_i = 1'($urandom);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        chk("busy_after", busy_o, 1'b0);
        chk("done_once", done_o, 1'b0);
        chk("rdata_after", rdata_o, exp_rdata);
    endtask

    initial begin
        vec_t r;

        //           we    base      stride  ackp rnd scyc rsta exp_done
        tbl[0] = '{1'b0, 16'h0100, 16'd1, 1, 1'b0, 0, 0, 17};  // unit-stride load
        tbl[1] = '{1'b1, 16'h0200, 16'd2, 3, 1'b0, 0, 0, 49};  // strided store with waits
        tbl[2] = '{1'b0, 16'hFFFE, 16'd1, 1, 1'b0, 0, 0, 17};  // address wrap
        tbl[3] = '{1'b0, 16'h0400, 16'd3, 1, 1'b0, 5, 0, 17};  // start while busy
        tbl[4] = '{1'b0, 16'h0500, 16'd1, 1, 1'b0, 0, 5, 0};   // reset after 5 acks
        tbl[5] = '{1'b0, 16'h0300, 16'd1, 1, 1'b0, 0, 0, 17};  // restart after reset

        // Reset with random inputs, clock running.
        rst_n       = 1'b0;
        start_i     = 1'b1;
        we_i        = 1'($urandom);
        base_addr_i = AW'($urandom);
        stride_i    = AW'($urandom);
        for (int i = 0; i < M; i++) wdata_i[i] = N'($urandom);
        mem_rdata_i = N'($urandom);
        mem_ack_i   = 1'b1;
        exp_rdata   = '0;
        #3;
        chk_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("reset_held");
        start_i = 1'b0;
        rst_n   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_ack_i = 1'($urandom);
            @(posedge clk); #1;
            chk("idle_busy", busy_o, 1'b0);
            chk("idle_req", mem_req_o, 1'b0);
            chk("idle_done", done_o, 1'b0);
        end
        mem_ack_i = 1'b0;

        for (int t = 0; t < 6; t++) run_op(tbl[t]);

        for (int t = 0; t < 20; t++) begin
            r.we         = 1'($urandom);
            r.base       = AW'($urandom);
            r.stride     = (t % 5 == 0) ? AW'(0) : AW'($urandom);
            r.ack_period = 0;
            r.rnd        = 1'b1;
            r.start_cyc  = (t % 4 == 1) ? int'($urandom_range(1, 10)) : 0;
            r.rst_after  = (t % 7 == 3) ? int'($urandom_range(1, M - 1)) : 0;
            r.exp_done   = 0;
            run_op(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_mem_sequencer.md
# vec_mem_sequencer

Vector load/store sequencer for the vector CPU datapath. Splits one vector memory operation of M lanes × N bits into M single-element accesses on a scalar memory port. Loads are assembled into a full-lane vector that feeds the memory input of the writeback vector select stage. Stores emit the lanes of a captured source vector in lane order.

## Interface
- `N`, 16, element width in bits
- `M`, 16, lane count; M ≥ 2
- `AW`, 16, memory address width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request a vector operation; accepted only in IDLE
- `we`  in  1  operation type, sampled with `start`: 1 = store, 0 = load
- `base_addr`  in  AW  lane-0 address, sampled with `start`
- `stride`  in  AW  address increment between lanes, sampled with `start`
- `wdata`  in  [M-1:0][N-1:0]  store vector, sampled with `start`
- `busy`  out  1  high whenever the sequencer is not in IDLE
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  [M-1:0][N-1:0]  last completed load vector
- `mem_req`  out  1  element access request
- `mem_we`  out  1  element write enable
- `mem_addr`  out  AW  element address
- `mem_wdata`  out  N  element write data
- `mem_rdata`  in  N  element read data; valid only while `mem_ack` is high
- `mem_ack`  in  1  completes the current access

## Operation
- FSM states:
  - IDLE: `start` = 1 captures `we`, `base_addr`, `stride`, `wdata`; clears lane index `idx` to 0; goes to REQ.
  - REQ: holds `mem_req` = 1 with stable `mem_addr`, `mem_we` and `mem_wdata` until `mem_ack` is high.
    - On ack with `idx` < M-1: `idx` += 1; address += `stride`.
    - On ack with `idx` = M-1: goes to DONE.
  - DONE: `done` = 1 for one cycle; goes to IDLE.
- Address arithmetic is modulo 2^AW. Wrap-around is silent; there is no overflow flag.
- `idx` width is $clog2(M).
- Loads: on each ack, `mem_rdata` is written into a shadow buffer at lane `idx`.
- On the transition to DONE, the whole shadow buffer (including the final lane) is copied to `rdata`. `rdata` therefore never shows a partially assembled vector. It holds its value until the next load completes.
- Stores: `mem_wdata` = captured `wdata[idx]`. Stores never modify `rdata`.
- `start` while busy is ignored. It has no effect on the operation in flight and is not queued.
- `mem_ack` while `mem_req` = 0 is ignored.
- Asserting `rst_n` mid-operation aborts immediately: the FSM returns to IDLE and any partial load is discarded.

## Timing
- Reset values:
  - FSM = IDLE.
  - `busy`, `done`, `mem_req` and `mem_we` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `rdata` = 0, shadow buffer = 0, `idx` = 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `start` sampled at edge 0:
  - `busy` and `mem_req` rise after edge 0.
  - The first access is presented in cycle 1.
- `mem_ack` may be high in the first cycle of a request, so a single access completes in 1 cycle at minimum.
- With `mem_ack` held at 1:
  - Accesses occupy cycles 1..M.
  - `done` and the new `rdata` are visible in cycle M+1.
  - `busy` falls after cycle M+1.
  - A new `start` is accepted in cycle M+2.
- Each wait cycle (`mem_ack` = 0 during REQ) adds exactly 1 cycle of latency.
- `done` and the updated `rdata` appear in the same cycle.

## Structure
- Shared package `vec_pkg`:
  - FSM state enum `vseq_state_t` {IDLE, REQ, DONE}.
  - Default N, M and AW constants shared with the other vector components.
- Single module; no sub-module is required. The address register and `idx` counter stay inline.

## Test plan
- **Reset:** drive `rst_n` low with random inputs → all outputs 0, `busy` = 0; after release, the FSM idles until `start`.
- **Unit-stride load:** `base_addr` = 0x0100, `stride` = 1, `mem_ack` held at 1, memory returns its address as data → `mem_addr` runs 0x0100..0x010F in cycles 1..16; `done` in cycle 17 with `rdata[i]` = 0x0100+i; `rdata` is unchanged before cycle 17.
- **Strided store with waits:** `base_addr` = 0x0200, `stride` = 2, `wdata[i]` = 0xA000+i, `mem_ack` every 3rd cycle of each request → lane i is written at 0x0200+2i with data 0xA000+i; request outputs are stable across waits; `done` in cycle 49; `rdata` is unchanged.
- **Address wrap:** load with `base_addr` = 0xFFFE, `stride` = 1 → addresses are 0xFFFE, 0xFFFF, 0x0000..0x000D; lanes land in order.
- **Busy start:** pulse `start` (load, different base) in cycle 5 of an operation → ignored; the original sequence completes unchanged; exactly one `done`.
- **Mid-load reset:** assert `rst_n` low after 5 acks → IDLE, `rdata` = 0, no `done`; a following load with `base_addr` = 0x0300 restarts at lane 0 and completes normally.
